// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronized input, free-running 16x oversample tick,
// mid-bit sampling, one-cycle rx_done / frame_err strobes.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            state     <= IDLE;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    // Only a 1->0 transition starts a frame, so a held-low break is ignored.
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        samp_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt == 4'd7) begin
                            samp_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                        if (samp_cnt == 4'd15) begin
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state    <= STOP;
                                samp_cnt <= '0;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (samp_cnt == 4'd15) begin
                            if (rx_s) begin
                                rx_data <= shreg;
                                rx_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state    <= IDLE;
                            samp_cnt <= '0;
                            rx_busy  <= 1'b0;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive side of the UART link; the counterpart of the existing transmitter.
- Decodes 8N1 frames on rxd, LSB first, idle-high line, using a self-contained 16x oversampling tick.
- Presents each received byte on rx_data with a one-cycle rx_done strobe and flags bad stop bits.
- Sits at the pin boundary beside the transmit path. Shares the system clock but does not share the transmitter's baud tick.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Fixed at 16; other values are unsupported.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE): clocks per oversample tick, integer division. Default is 651.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- rxd  input  1  asynchronous serial input, idles high.
- rx_data  output  8  last correctly received byte.
- rx_done  output  1  one-cycle strobe: rx_data was just updated.
- rx_busy  output  1  high while a frame is being received.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Synchronizer flops and edge-detect flop load 1.
  - Tick counter, sample counter and bit counter clear to 0.
  - State goes to IDLE.
  - Outputs reset to rx_data=8'h00, rx_done=0, rx_busy=0, frame_err=0.
  - Reset asserted mid-frame aborts the frame: no rx_done, no frame_err, and rx_data is cleared.
- Input path:
  - rxd passes through a 2-FF synchronizer to give rx_s.
  - rx_prev holds rx_s delayed one clock.
  - All decisions use rx_s.
- Tick generator:
  - Free-running counter, 0..TICK_DIV-1.
  - tick=1 for one clock when count==TICK_DIV-1, then the counter wraps to 0.
  - The counter runs in every state.
- Sample counter: 4-bit, increments on each tick inside START, DATA and STOP. It is cleared on every state entry.
- IDLE:
  - rx_busy=0.
  - A falling edge (rx_prev==1 && rx_s==0) moves to START.
  - A line held low (break) is not a start; a new frame needs a 1->0 edge.
- START:
  - On the tick where the sample counter is 7 (mid start bit):
    - rx_s==0: go to DATA and clear the bit counter.
    - rx_s==1: treat as a glitch and return to IDLE with no output activity.
- DATA:
  - On the tick where the sample counter is 15 (mid bit):
    - Shift rx_s into the shift register MSB and shift right, so bit0 is received first.
    - Increment the 3-bit bit counter.
  - After the 8th sample (bit counter was 7), go to STOP.
- STOP:
  - On the tick where the sample counter is 15:
    - rx_s==1: rx_data <= shift register and rx_done=1 for exactly one clock.
    - rx_s==0: frame_err=1 for exactly one clock; rx_data holds its previous value and rx_done stays 0.
  - In both cases the next state is IDLE. rx_done and frame_err are never high together.
- rx_busy is 1 in START, DATA and STOP; it drops in the same cycle IDLE is re-entered.
- Timing:
  - Decision at mid stop bit, about 9.5 bit times after the start edge.
  - Plus 2–3 clocks of synchronizer/edge latency.
  - Plus up to 1 tick of phase error from the free-running tick.
- Back-to-back frames: a start edge arriving one clock after STOP exits is accepted; there is no dead time beyond the IDLE edge detect.

Test Plan:
- Single byte:
  - Stimulus: after reset release, drive 8'h55 at 9600 baud, 10416 clk/bit.
  - Required: exactly one rx_done pulse, one clock wide, about 98,950 clk after the start edge (±1 tick); rx_data==8'h55; frame_err never asserted.
- Back-to-back bytes:
  - Stimulus: 8'hA3 then 8'h0F with no idle gap.
  - Required: two rx_done pulses with rx_data 8'hA3 then 8'h0F; rx_busy low for at most a few clocks between frames.
- Glitch rejection:
  - Stimulus: rxd low for 3 ticks (about 1953 clk), then high.
  - Required: rx_busy pulses and then returns low before 8 ticks; no rx_done, no frame_err.
- Framing error:
  - Stimulus: send 8'h3C with the stop bit driven low, after a good 8'h81.
  - Required: one frame_err pulse, no rx_done, rx_data stays 8'h81.
  - Continuation: hold rxd low for 2 more bit times, then high, then send 8'h77; only 8'h77 is received.
- Reset mid-frame:
  - Stimulus: assert reset low during data bit 4 of 8'hFF.
  - Required: all outputs 0 on the next edge; no strobes.
  - Continuation: after release, drive idle then 8'h12; rx_data==8'h12.
- Loopback:
  - Stimulus: connect the transmitter's txd to rxd; send 8'hC7, 8'h00, 8'hFF.
  - Required: each received byte matches, in order, with no frame_err.
